// File: rtl/drbg_rand_streamer.sv
// Sequencer/consumer for an AES-256 CTR_DRBG generate core: holds the working state,
// issues generate requests, and streams each 256-bit block as eight 32-bit words.
module drbg_rand_streamer #(
   parameter logic [31:0] RESEED_INTERVAL = 32'h0001_0000,
   parameter logic [31:0] REQ_BITS        = 32'd256
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inst_load,
   input  logic [255:0] inst_key,
   input  logic [127:0] inst_v,
   input  logic         enable,
   output logic         gen_start,
   output logic [31:0]  gen_requested_bits,
   output logic [383:0] gen_additional_input,
   output logic [255:0] state_key,
   output logic [127:0] state_v,
   output logic [31:0]  state_reseed_counter,
   input  logic         gen_done,
   input  logic         gen_error,
   input  logic [255:0] gen_random_bits,
   input  logic [255:0] gen_key_out,
   input  logic [127:0] gen_v_out,
   input  logic [31:0]  gen_reseed_counter_out,
   output logic [31:0]  out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         reseed_required,
   output logic         error
);

   localparam int unsigned BLK_W  = 256;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned ADD_W  = 384;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_WAIT   = 3'd2,
      S_STREAM = 3'd3,
      S_RESEED = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic               state_valid;
   logic [BLK_W-1:0]   blk_q;
   logic [IDX_W-1:0]   idx;

   logic               over_c;
   logic               hs_c;
   logic               last_c;
   logic               load_c;
   logic               capture_c;
   logic               shift_c;

   assign gen_requested_bits   = REQ_BITS;
   assign gen_additional_input = ADD_W'(0);
   assign out_data             = blk_q[BLK_W-1 -: WORD_W];

   assign over_c = state_reseed_counter > RESEED_INTERVAL;
   assign hs_c   = out_valid & out_ready;
   assign last_c = idx == IDX_W'(7);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // Next-state logic; inst_load takes priority wherever it is honoured
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (inst_load)                         state_nx = S_IDLE;
            else if (state_valid && over_c)        state_nx = S_RESEED;
            else if (state_valid && enable)        state_nx = S_REQ;
         end
         S_REQ:    state_nx = S_WAIT;
         S_WAIT: begin
            if (gen_done) state_nx = gen_error ? S_ERR : S_STREAM;
         end
         S_STREAM: begin
            if (inst_load)             state_nx = S_IDLE;
            else if (hs_c && last_c)   state_nx = S_IDLE;
         end
         S_RESEED, S_ERR: begin
            if (inst_load) state_nx = S_IDLE;
         end
         default:  state_nx = S_IDLE;
      endcase
   end

   // Datapath strobes decoded from the current state
   always_comb begin
      load_c    = 1'b0;
      capture_c = 1'b0;
      shift_c   = 1'b0;
      case (state)
         S_IDLE, S_RESEED, S_ERR: load_c = inst_load;
         S_STREAM: begin
            load_c  = inst_load;
            shift_c = hs_c & ~inst_load;
         end
         S_WAIT:   capture_c = gen_done & ~gen_error;
         default: begin
            load_c    = 1'b0;
            capture_c = 1'b0;
            shift_c   = 1'b0;
         end
      endcase
   end

   // Registered outputs, working state and the word buffer (shifted MSB-first)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gen_start            <= 1'b0;
         out_valid            <= 1'b0;
         reseed_required      <= 1'b0;
         error                <= 1'b0;
         state_key            <= '0;
         state_v              <= '0;
         state_reseed_counter <= '0;
         state_valid          <= 1'b0;
         blk_q                <= '0;
         idx                  <= '0;
      end else begin
         gen_start       <= state_nx == S_REQ;
         out_valid       <= state_nx == S_STREAM;
         reseed_required <= state_nx == S_RESEED;
         error           <= state_nx == S_ERR;
         if (load_c) begin
            state_key            <= inst_key;
            state_v              <= inst_v;
            state_reseed_counter <= 32'd1;
            state_valid          <= 1'b1;
            idx                  <= '0;
         end else if (capture_c) begin
            state_key            <= gen_key_out;
            state_v              <= gen_v_out;
            state_reseed_counter <= gen_reseed_counter_out;
            blk_q                <= gen_random_bits;
            idx                  <= '0;
         end else if (shift_c) begin
            blk_q <= {blk_q[BLK_W-WORD_W-1:0], WORD_W'(0)};
            idx   <= IDX_W'(idx + IDX_W'(1));
         end
      end
   end

endmodule

// File: tb/tb_drbg_rand_streamer.sv
// Randomized bench for drbg_rand_streamer: the bench acts as generate_drbg and tracks
// the expected working state and word stream from the block-level rules.
module tb_drbg_rand_streamer;

   localparam logic [31:0] RI = 32'd2;

   logic         clk = 1'b0;
   logic         rst;
   logic         inst_load;
   logic [255:0] inst_key;
   logic [127:0] inst_v;
   logic         enable;
   logic         gen_start;
   logic [31:0]  gen_requested_bits;
   logic [383:0] gen_additional_input;
   logic [255:0] state_key;
   logic [127:0] state_v;
   logic [31:0]  state_reseed_counter;
   logic         gen_done;
   logic         gen_error;
   logic [255:0] gen_random_bits;
   logic [255:0] gen_key_out;
   logic [127:0] gen_v_out;
   logic [31:0]  gen_reseed_counter_out;
   logic [31:0]  out_data;
   logic         out_valid;
   logic         out_ready;
   logic         reseed_required;
   logic         error;

   int n_chk  = 0;
   int n_fail = 0;

   logic [255:0] m_key;
   logic [127:0] m_v;
   logic [31:0]  m_cnt;

   drbg_rand_streamer #(.RESEED_INTERVAL(RI), .REQ_BITS(32'd256)) dut (
      .clk(clk), .rst(rst), .inst_load(inst_load), .inst_key(inst_key), .inst_v(inst_v),
      .enable(enable), .gen_start(gen_start), .gen_requested_bits(gen_requested_bits),
      .gen_additional_input(gen_additional_input), .state_key(state_key), .state_v(state_v),
      .state_reseed_counter(state_reseed_counter), .gen_done(gen_done), .gen_error(gen_error),
      .gen_random_bits(gen_random_bits), .gen_key_out(gen_key_out), .gen_v_out(gen_v_out),
      .gen_reseed_counter_out(gen_reseed_counter_out), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .reseed_required(reseed_required), .error(error)
   );

   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] rand256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check_zero_outputs(input string tag);
      check({tag, "_gen_start"}, 256'(gen_start), 256'd0);
      check({tag, "_out_valid"}, 256'(out_valid), 256'd0);
      check({tag, "_reseed"},    256'(reseed_required), 256'd0);
      check({tag, "_error"},     256'(error), 256'd0);
      check({tag, "_key"},       state_key, 256'd0);
      check({tag, "_v"},         256'(state_v), 256'd0);
      check({tag, "_cnt"},       256'(state_reseed_counter), 256'd0);
      check({tag, "_data"},      256'(out_data), 256'd0);
      check({tag, "_reqbits"},   256'(gen_requested_bits), 256'd256);
      check({tag, "_addin"},     256'(gen_additional_input), 256'd0);
   endtask

   task automatic load(input logic [255:0] k, input logic [127:0] v);
      inst_key  = k;
      inst_v    = v;
      inst_load = 1'b1;
      tick();
      inst_load = 1'b0;
      m_key = k;
      m_v   = v;
      m_cnt = 32'd1;
      check("load_key",    state_key, m_key);
      check("load_v",      256'(state_v), 256'(m_v));
      check("load_cnt",    256'(state_reseed_counter), 256'd1);
      check("load_error",  256'(error), 256'd0);
      check("load_reseed", 256'(reseed_required), 256'd0);
      check("load_valid",  256'(out_valid), 256'd0);
   endtask

   // Act as generate_drbg for one request: wait for start, answer after lat cycles
   task automatic request(input logic [255:0] bits, input logic [255:0] ko, input logic [127:0] vo,
                          input logic [31:0] co, input logic err, input int lat);
      for (int i = 0; i < 20 && !gen_start; i++) tick();
      check("gen_start_seen", 256'(gen_start), 256'd1);
      check("req_key", state_key, m_key);
      check("req_v",   256'(state_v), 256'(m_v));
      check("req_cnt", 256'(state_reseed_counter), 256'(m_cnt));
      tick();
      check("gen_start_pulse", 256'(gen_start), 256'd0);
      repeat (lat - 1) tick();
      gen_random_bits        = bits;
      gen_key_out            = ko;
      gen_v_out              = vo;
      gen_reseed_counter_out = co;
      gen_error              = err;
      gen_done               = 1'b1;
      tick();
      gen_done  = 1'b0;
      gen_error = 1'b0;
      if (!err) begin
         m_key = ko;
         m_v   = vo;
         m_cnt = co;
         check("done_valid", 256'(out_valid), 256'd1);
      end else begin
         check("err_flag",  256'(error), 256'd1);
         check("err_valid", 256'(out_valid), 256'd0);
      end
      check("upd_key", state_key, m_key);
      check("upd_v",   256'(state_v), 256'(m_v));
      check("upd_cnt", 256'(state_reseed_counter), 256'(m_cnt));
   endtask

   // Drain eight words with toggling or random out_ready, then check the restart gap
   task automatic stream(input logic [255:0] bits, input logic toggle);
      int           hs = 0;
      logic         pstall = 1'b0;
      logic [31:0]  pd = '0;
      logic         exp_start;
      for (int c = 0; c < 300 && hs < 8; c++) begin
         if (pstall) begin
            check("hold_valid", 256'(out_valid), 256'd1);
            check("hold_data",  256'(out_data), 256'(pd));
         end
         out_ready = toggle ? c[0] : 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            check($sformatf("word%0d", hs), 256'(out_data), 256'(bits[255 - 32*hs -: 32]));
            hs++;
         end
         pstall = out_valid && !out_ready;
         pd     = out_data;
         tick();
      end
      out_ready = 1'b0;
      check("handshakes", 256'(hs), 256'd8);
      check("valid_drop", 256'(out_valid), 256'd0);
      check("gap_start1", 256'(gen_start), 256'd0);
      tick();
      exp_start = enable && (m_cnt <= RI);
      check("gap_start2", 256'(gen_start), 256'(exp_start));
      check("gap_reseed", 256'(reseed_required), 256'(m_cnt > RI));
   endtask

   initial begin
      logic [255:0] k;
      logic [127:0] v;
      logic [255:0] bits;

      rst = 1'b0; inst_load = 1'b0; inst_key = '0; inst_v = '0; enable = 1'b0;
      gen_done = 1'b0; gen_error = 1'b0; gen_random_bits = '0; gen_key_out = '0;
      gen_v_out = '0; gen_reseed_counter_out = '0; out_ready = 1'b0;
      repeat (3) tick();
      check_zero_outputs("reset");
      rst = 1'b1;
      enable = 1'b1;

      // No state loaded: nothing may happen
      for (int i = 0; i < 100; i++) begin
         tick();
         check("noload_idle", 256'({gen_start, out_valid}), 256'd0);
      end

      // Known-answer request with toggling ready
      for (int i = 0; i < 32; i++) k[255 - 8*i -: 8] = 8'(i);
      for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = 8'(i);
      load(k, v);
      bits = 256'h00112233_44556677_8899aabb_ccddeeff_00112233_44556677_8899aabb_ccddeeff;
      request(bits, rand256(), rand128(), 32'd2, 1'b0, 5);
      stream(bits, 1'b1);
      bits = rand256();
      request(bits, rand256(), rand128(), 32'd3, 1'b0, 3);
      stream(bits, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("reseed_hold",  256'(reseed_required), 256'd1);
         check("reseed_nogen", 256'(gen_start), 256'd0);
      end

      // Randomized load / two generates / reseed rounds
      for (int r = 0; r < 4; r++) begin
         if (r == 1) enable = 1'b0;
         load(rand256(), rand128());
         if (r == 1) begin
            for (int i = 0; i < 10; i++) begin
               tick();
               check("enable_low", 256'(gen_start), 256'd0);
            end
            enable = 1'b1;
         end
         for (int g = 0; g < 2; g++) begin
            bits = rand256();
            request(bits, rand256(), rand128(), m_cnt + 32'd1, 1'b0, int'($urandom_range(1, 6)));
            stream(bits, 1'b0);
         end
      end

      // Generate error path
      load(rand256(), rand128());
      request(rand256(), rand256(), rand128(), 32'd2, 1'b1, 2);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("err_sticky", 256'(error), 256'd1);
         check("err_noout",  256'({gen_start, out_valid}), 256'd0);
         check("err_key",    state_key, m_key);
      end
      load(rand256(), rand128());

      // Reset while waiting for the generate core
      for (int i = 0; i < 20 && !gen_start; i++) tick();
      check("rst_pre_start", 256'(gen_start), 256'd1);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check_zero_outputs("rst_wait");
      tick();
      rst = 1'b1;
      gen_random_bits = rand256();
      gen_key_out     = rand256();
      gen_done        = 1'b1;
      tick();
      gen_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("post_rst_valid", 256'(out_valid), 256'd0);
         check("post_rst_start", 256'(gen_start), 256'd0);
         check("post_rst_key",   state_key, 256'd0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
